// File: rtl/pulse_width_pkg.sv
// Shared types for the pulse width detector: per-channel FSM state encoding.
package pulse_width_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        ACTIVE,
        OVER
    } pw_state_e;

endpackage

// File: rtl/pulse_width_channel.sv
// One channel: measures an active pulse (polarity selected by pol) and flags
// pulses whose width lies in [MIN_W, MAX_W] or that run past MAX_W.
module pulse_width_channel
    import pulse_width_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int MIN_W = 1,
    parameter int MAX_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             pol,
    output logic             detected,
    output logic             too_long,
    output logic [CNT_W-1:0] width
);

    if (MIN_W < 1 || MIN_W > MAX_W || MAX_W > (2 ** CNT_W) - 1) begin : g_bad_params
        $error("pulse_width_channel: need 1 <= MIN_W <= MAX_W <= 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_W);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_W);

    pw_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             pol_q;
    logic             a_eff;
    logic             pol_chg;
    logic             det_d;
    logic             tl_d;

    always_comb begin
        a_eff   = a ^ pol_q;
        pol_chg = pol ^ pol_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        det_d   = 1'b0;
        tl_d    = 1'b0;
        // A polarity change invalidates whatever was being measured.
        if (pol_chg) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!a_eff) state_d = ARMED;
                end
                ARMED: begin
                    if (a_eff) begin
                        state_d = ACTIVE;
                        cnt_d   = CNT_W'(1);
                    end
                end
                ACTIVE: begin
                    if (a_eff) begin
                        if (cnt_q < MAX_CNT) begin
                            cnt_d = cnt_q + 1'b1;
                        end else begin
                            state_d = OVER;
                            tl_d    = 1'b1;
                        end
                    end else begin
                        state_d = ARMED;
                        cnt_d   = '0;
                        if (cnt_q >= MIN_CNT) begin
                            det_d   = 1'b1;
                            width_d = cnt_q;
                        end
                    end
                end
                OVER: begin
                    if (!a_eff) begin
                        state_d = ARMED;
                        cnt_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            width_q <= '0;
            pol_q   <= pol;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            pol_q   <= pol;
        end
    end

    assign detected = det_d & rst_n;
    assign too_long = tl_d & rst_n;
    assign width    = width_q;

endmodule

// File: rtl/multi_channel_pulse_width_detector.sv
// N_CH independent pulse width detectors; this level only slices the buses.
module multi_channel_pulse_width_detector #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8,
    parameter int MIN_W = 1,
    parameter int MAX_W = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       a,
    input  logic [N_CH-1:0]       pol,
    output logic [N_CH-1:0]       detected,
    output logic [N_CH-1:0]       too_long,
    output logic [N_CH*CNT_W-1:0] width
);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        pulse_width_channel #(
            .CNT_W(CNT_W),
            .MIN_W(MIN_W),
            .MAX_W(MAX_W)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .a       (a[gi]),
            .pol     (pol[gi]),
            .detected(detected[gi]),
            .too_long(too_long[gi]),
            .width   (width[gi*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_multi_channel_pulse_width_detector.sv
// Two detector instances (default MIN/MAX and MIN_W=3/MAX_W=5) driven by directed
// and random stimulus, compared every cycle against a run-length reference model.
module tb_multi_channel_pulse_width_detector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  a_d, pol_d, a_w, pol_w;
    logic [3:0]  det0, tl0, det1, tl1;
    logic [31:0] wid0, wid1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multi_channel_pulse_width_detector dut_def (
        .clk(clk), .rst_n(rst_n), .a(a_d), .pol(pol_d),
        .detected(det0), .too_long(tl0), .width(wid0)
    );

    multi_channel_pulse_width_detector #(.N_CH(4), .CNT_W(8), .MIN_W(3), .MAX_W(5)) dut_w (
        .clk(clk), .rst_n(rst_n), .a(a_w), .pol(pol_w),
        .detected(det1), .too_long(tl1), .width(wid1)
    );

    // Reference model: qualified = an inactive cycle seen since reset/pol change,
    // run = length of the current active run counted only once qualified.
    bit         qual [2][4];
    int         run  [2][4];
    logic [7:0] mw   [2][4];
    logic       ppol [2][4];
    bit         model_init = 1'b0;
    logic [3:0] det_s [2];
    logic [3:0] tl_s  [2];

    function automatic int min_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int max_of(input int d);
        return (d == 0) ? 1 : 5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic [3:0]  ea [2];
        logic [3:0]  ep [2];
        logic [3:0]  pd [2];
        logic [3:0]  pt [2];
        logic [31:0] ew;
        logic        act;
        ea[0] = a_d; ep[0] = pol_d;
        ea[1] = a_w; ep[1] = pol_w;
        for (int d = 0; d < 2; d++) begin
            pd[d] = '0;
            pt[d] = '0;
            for (int c = 0; c < 4; c++) begin
                if (rst_n && model_init && ep[d][c] == ppol[d][c]) begin
                    act = ea[d][c] ^ ppol[d][c];
                    if (act)
                        pt[d][c] = qual[d][c] && (run[d][c] + 1 == max_of(d) + 1);
                    else
                        pd[d][c] = qual[d][c] && run[d][c] >= min_of(d) && run[d][c] <= max_of(d);
                end
            end
        end
        #2;
        det_s[0] = det0; tl_s[0] = tl0;
        det_s[1] = det1; tl_s[1] = tl1;
        chk("det_def", {28'd0, det0}, {28'd0, pd[0]});
        chk("tl_def",  {28'd0, tl0},  {28'd0, pt[0]});
        chk("det_w",   {28'd0, det1}, {28'd0, pd[1]});
        chk("tl_w",    {28'd0, tl1},  {28'd0, pt[1]});
        if (model_init) begin
            for (int c = 0; c < 4; c++) ew[c*8 +: 8] = mw[0][c];
            chk("width_def", wid0, ew);
            for (int c = 0; c < 4; c++) ew[c*8 +: 8] = mw[1][c];
            chk("width_w", wid1, ew);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                if (!rst_n) begin
                    qual[d][c] = 1'b0;
                    run[d][c]  = 0;
                    mw[d][c]   = 8'd0;
                    ppol[d][c] = ep[d][c];
                end else if (ep[d][c] != ppol[d][c]) begin
                    qual[d][c] = 1'b0;
                    run[d][c]  = 0;
                    ppol[d][c] = ep[d][c];
                end else if (ea[d][c] ^ ppol[d][c]) begin
                    if (qual[d][c]) run[d][c]++;
                end else begin
                    if (pd[d][c]) mw[d][c] = 8'(run[d][c]);
                    qual[d][c] = 1'b1;
                    run[d][c]  = 0;
                end
            end
        end
        if (!rst_n) model_init = 1'b1;
    endtask

    task automatic set_a(input bit on_w, input int ch, input logic v);
        if (on_w) a_w[ch] = v;
        else      a_d[ch] = v;
    endtask

    // Drive an active pulse of len cycles then one inactive cycle.
    task automatic pulse(input bit on_w, input int ch, input int len, output bit det, output int tl_at);
        logic lvl;
        lvl   = on_w ? ~pol_w[ch] : ~pol_d[ch];
        tl_at = 0;
        for (int k = 1; k <= len; k++) begin
            set_a(on_w, ch, lvl);
            step();
            if (on_w ? tl_s[1][ch] : tl_s[0][ch]) tl_at = k;
        end
        set_a(on_w, ch, ~lvl);
        step();
        det = on_w ? det_s[1][ch] : det_s[0][ch];
    endtask

    initial begin
        bit det;
        int tl_at;
        rst_n = 1'b0;
        a_d = '0; pol_d = '0; a_w = '0; pol_w = '0;
        step();
        step();
        chk("rst_det", {28'd0, det_s[0]}, 32'd0);
        chk("rst_width", wid0, 32'd0);
        chk("rst_width_w", wid1, 32'd0);
        rst_n = 1'b1;

        // Defaults: 1-cycle pulse detected, 2-cycle pulse flagged too long.
        step();
        pulse(0, 0, 1, det, tl_at);
        chk("t1_det", {31'd0, det}, 32'd1);
        chk("t1_width", {24'd0, wid0[7:0]}, 32'd1);
        pulse(0, 0, 2, det, tl_at);
        chk("t1_tl_cycle", tl_at, 2);
        chk("t1_long_nodet", {31'd0, det}, 32'd0);

        // MIN_W=3 MAX_W=5 on the second instance.
        pulse(1, 0, 2, det, tl_at);
        chk("t2_short", {31'd0, det}, 32'd0);
        pulse(1, 0, 3, det, tl_at);
        chk("t2_det3", {31'd0, det}, 32'd1);
        chk("t2_w3", {24'd0, wid1[7:0]}, 32'd3);
        pulse(1, 0, 5, det, tl_at);
        chk("t2_det5", {31'd0, det}, 32'd1);
        chk("t2_w5", {24'd0, wid1[7:0]}, 32'd5);
        pulse(1, 0, 6, det, tl_at);
        chk("t2_tl6", tl_at, 6);
        chk("t2_nodet6", {31'd0, det}, 32'd0);
        chk("t2_wkeep", {24'd0, wid1[7:0]}, 32'd5);

        // Low-polarity channel.
        pol_w[1] = 1'b1; a_w[1] = 1'b1;
        step();
        step();
        pulse(1, 1, 4, det, tl_at);
        chk("t3_det", {31'd0, det}, 32'd1);
        chk("t3_width", {24'd0, wid1[15:8]}, 32'd4);
        a_w[1] = 1'b0;
        for (int k = 0; k < 8; k++) step();
        a_w[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3_high_ign", {31'd0, det_s[1][1]}, 32'd0);
        end

        // Pulse already in progress when reset releases is ignored.
        a_d[0] = 1'b1; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        a_d[0] = 1'b0;
        step();
        chk("t4_no_strobe", {31'd0, det_s[0][0]}, 32'd0);
        pulse(0, 0, 1, det, tl_at);
        chk("t4_det_a", {31'd0, det}, 32'd1);
        pulse(0, 0, 1, det, tl_at);
        chk("t4_det_b", {31'd0, det}, 32'd1);

        // Reset mid-pulse.
        a_d[0] = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; a_d[0] = 1'b0;
        step();
        chk("t5_rst_nodet", {31'd0, det_s[0][0]}, 32'd0);
        pulse(0, 0, 1, det, tl_at);
        chk("t5_rst_next", {31'd0, det}, 32'd1);

        // Polarity change mid-pulse.
        pulse(1, 2, 4, det, tl_at);
        chk("t5_pre", {24'd0, wid1[23:16]}, 32'd4);
        a_w[2] = 1'b1;
        step();
        step();
        pol_w[2] = 1'b1;
        step();
        chk("t5_pol_chg", {31'd0, det_s[1][2]}, 32'd0);
        step();
        chk("t5_pol_after", {31'd0, det_s[1][2]}, 32'd0);
        chk("t5_wkeep", {24'd0, wid1[23:16]}, 32'd4);
        pulse(1, 2, 3, det, tl_at);
        chk("t5_pol_next", {31'd0, det}, 32'd1);
        chk("t5_wnew", {24'd0, wid1[23:16]}, 32'd3);

        // All four channels at once.
        a_d = 4'b0000;
        step();
        a_d = 4'b1111;
        step();
        a_d = 4'b0000;
        step();
        chk("t6_all", {28'd0, det_s[0]}, 32'hf);

        for (int n = 0; n < 10000; n++) begin
            rst_n = ($urandom_range(0, 999) != 0);
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 2) == 0) a_d[c] = ~a_d[c];
                if ($urandom_range(0, 3) == 0) a_w[c] = ~a_w[c];
                if ($urandom_range(0, 299) == 0) pol_d[c] = ~pol_d[c];
                if ($urandom_range(0, 299) == 0) pol_w[c] = ~pol_w[c];
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
